// File: rtl/fluxcore_pkg.sv
// Types and constants shared between the return stack and the PC counter.
package fluxcore_pkg;

  localparam int PC_WIDTH = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } stack_state_t;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are only ever read below sp, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Call/return stack feeding the PC counter's load port; holds sp, the RUN/FAULT FSM,
// the sticky fault flags and the registered load strobe.
module return_stack
  import fluxcore_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_addr,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             load_addr,
  output logic                         load_en,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  output stack_state_t                 dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  // Handshake: push/pop are single-cycle requests with no ready; each accepted pop
  // yields exactly one load_en cycle (valid, no backpressure) the cycle after it is sampled.

  stack_state_t     state_q, state_d;
  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] load_addr_q, load_addr_d;
  logic             load_en_q, load_en_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [AW-1:0]    rf_raddr;
  logic [WIDTH-1:0] rf_rdata;
  logic [CW-1:0]    sp_m1;
  logic             is_empty, is_full;

  assign sp_m1    = sp_q - CW'(1);
  assign rf_raddr = sp_m1[AW-1:0];
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (push_addr),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    load_addr_d = load_addr_q;
    load_en_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rf_we       = 1'b0;
    rf_waddr    = sp_q[AW-1:0];

    if (flush) begin
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      state_d     = RUN;
    end else if (state_q == RUN) begin
      unique case ({push, pop})
        2'b10: begin
          if (is_full) begin
            overflow_d = 1'b1;
            state_d    = FAULT;
          end else begin
            rf_we = 1'b1;
            sp_d  = sp_q + CW'(1);
          end
        end
        2'b01: begin
          if (is_empty) begin
            underflow_d = 1'b1;
            state_d     = FAULT;
          end else begin
            load_addr_d = rf_rdata;
            load_en_d   = 1'b1;
            sp_d        = sp_m1;
          end
        end
        2'b11: begin
          // Tail call: return to the current top and replace it in place.
          if (is_empty) begin
            underflow_d = 1'b1;
            state_d     = FAULT;
          end else begin
            load_addr_d = rf_rdata;
            load_en_d   = 1'b1;
            rf_we       = 1'b1;
            rf_waddr    = sp_m1[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      sp_q        <= '0;
      load_addr_q <= '0;
      load_en_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      load_addr_q <= load_addr_d;
      load_en_q   <= load_en_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign load_addr = load_addr_q;
  assign load_en   = load_en_q;
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign dbg_state = state_q;

endmodule
